// File: rtl/fetch_pkg.sv
// Shared defaults and sizing helpers for the 65HE06 instruction fetch front end.
package fetch_pkg;

  localparam int          DW_DEF     = 16;
  localparam int          AW_DEF     = 16;
  localparam logic [15:0] RST_PC_DEF = 16'h0000;
  // Byte distance between consecutive instruction words.
  localparam int          WORD_INC   = 2;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// DEPTH x DW circular instruction buffer: one push, pop of one or two words, flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 4,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          a_rst,
  input  logic          push,
  input  logic [DW-1:0] data,
  input  logic          pop1,
  input  logic          pop2,
  input  logic          flush,
  output logic [DW-1:0] head,
  output logic [DW-1:0] head1,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd;
  logic [PW-1:0] wr;
  logic [PW-1:0] rd1;
  logic [CW-1:0] pop_n;
  logic [PW-1:0] rd_step;

  assign rd1   = rd + PW'(1);
  assign head  = mem[rd];
  assign head1 = mem[rd1];

  always_comb begin
    pop_n   = '0;
    rd_step = '0;
    if (pop2) begin
      pop_n   = CW'(2);
      rd_step = PW'(2);
    end else if (pop1) begin
      pop_n   = CW'(1);
      rd_step = PW'(1);
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= data;
        wr      <= wr + PW'(1);
      end
      rd    <= rd + rd_step;
      count <= count + CW'(push) - pop_n;
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: request issue, epoch-style stale response discard, redirect and PC tracking.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int          AW      = AW_DEF,
  parameter int          DW      = DW_DEF,
  parameter int          DEPTH   = 4,
  parameter int          MAX_OUT = 2,
  parameter logic [AW-1:0] RST_PC = AW'(RST_PC_DEF)
) (
  input  logic          clk,
  input  logic          a_rst,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  input  logic          hold,
  input  logic          pc_w,
  input  logic [AW-1:0] pc_alu,
  input  logic          ir_take,
  input  logic          ir_two,
  output logic          ir_valid,
  output logic [DW-1:0] ir_out,
  output logic [DW-1:0] k16_out,
  output logic [AW-1:0] pc_out
);

  localparam int CW = cnt_w(DEPTH);
  localparam int OW = $clog2(MAX_OUT) + 1;

  logic [CW-1:0] count;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] stale;
  logic [AW-1:0] fpc;
  logic [AW-1:0] target;
  logic [CW:0]   occ;
  logic          grant;
  logic          rsp_live;
  logic          rsp_stale;
  logic          push;
  logic          pop;
  logic          alu_lsb_unused;

  assign alu_lsb_unused = pc_alu[0];
  assign target         = {pc_alu[AW-1:1], 1'b0};

  // Slots already reserved by in-flight requests count as occupied.
  assign occ      = {1'b0, count} + (CW+1)'(outstanding);
  assign mem_req  = a_rst & ~hold & ~pc_w & (occ < (CW+1)'(DEPTH))
                    & (outstanding < OW'(MAX_OUT));
  assign mem_addr = fpc;
  assign grant    = mem_req & mem_gnt;

  assign rsp_stale = mem_rvalid & (stale != '0);
  assign rsp_live  = mem_rvalid & (stale == '0);
  assign push      = rsp_live & ~pc_w;
  assign ir_valid  = (count >= CW'(2));
  assign pop       = ir_take & ir_valid & ~hold & ~pc_w;

  fetch_queue #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .a_rst (a_rst),
    .push  (push),
    .data  (mem_rdata),
    .pop1  (pop & ~ir_two),
    .pop2  (pop & ir_two),
    .flush (pc_w),
    .head  (ir_out),
    .head1 (k16_out),
    .count (count)
  );

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      fpc    <= RST_PC;
      pc_out <= RST_PC;
    end else if (pc_w) begin
      fpc    <= target;
      pc_out <= target;
    end else begin
      if (grant) fpc <= fpc + AW'(WORD_INC);
      if (pop)   pc_out <= pc_out + (ir_two ? AW'(2 * WORD_INC) : AW'(WORD_INC));
    end
  end

  // On redirect every request still owed by memory becomes stale; a live
  // response landing in the redirect cycle is itself dropped, so it is not owed.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      outstanding <= '0;
      stale       <= '0;
    end else if (pc_w) begin
      outstanding <= '0;
      stale       <= stale - OW'(rsp_stale) + outstanding + OW'(grant) - OW'(rsp_live);
    end else begin
      outstanding <= outstanding + OW'(grant) - OW'(rsp_live);
      stale       <= stale - OW'(rsp_stale);
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a latency-selectable memory model and scoreboard queues.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        a_rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        hold;
  logic        pc_w;
  logic [15:0] pc_alu;
  logic        ir_take;
  logic        ir_two;
  logic        ir_valid;
  logic [15:0] ir_out;
  logic [15:0] k16_out;
  logic [15:0] pc_out;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] k16;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] addr_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          gcount = 0;
  int          lat = 1;
  logic        gnt_s = 1'b0;
  logic [15:0] addr_s = '0;
  logic        d1_v = 1'b0, d2_v = 1'b0;
  logic [15:0] d1_a = '0, d2_a = '0;

  fetch_queue_unit dut (
    .clk        (clk),
    .a_rst      (a_rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .hold       (hold),
    .pc_w       (pc_w),
    .pc_alu     (pc_alu),
    .ir_take    (ir_take),
    .ir_two     (ir_two),
    .ir_valid   (ir_valid),
    .ir_out     (ir_out),
    .k16_out    (k16_out),
    .pc_out     (pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memw(input logic [15:0] a);
    return 16'hA000 + {1'b0, a[15:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Grant monitor: samples the request port mid-cycle and checks queued expected addresses.
  always @(negedge clk) begin
    logic [15:0] ea;
    gnt_s  = a_rst & mem_req & mem_gnt;
    addr_s = mem_addr;
    if (gnt_s) begin
      gcount++;
      if (addr_q.size() > 0) begin
        ea = addr_q.pop_front();
        chk("mem_addr", 32'(mem_addr), 32'(ea));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!a_rst) begin
      d1_v = 1'b0;
      d2_v = 1'b0;
    end else begin
      d2_v = d1_v;
      d2_a = d1_a;
      d1_v = gnt_s;
      d1_a = addr_s;
    end
    mem_rvalid = (lat == 1) ? d1_v : d2_v;
    mem_rdata  = memw((lat == 1) ? d1_a : d2_a);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] pc);
    logic [15:0] pc2;
    pc2 = pc + 16'd2;
    sb_q.push_back('{pc, memw(pc), memw(pc2)});
  endtask

  task automatic check_head();
    int   n;
    exp_t e;
    n = 0;
    while (ir_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("ir_valid_wait", 32'(ir_valid), 32'd1);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("pc_out", 32'(pc_out), 32'(e.pc));
      chk("ir_out", 32'(ir_out), 32'(e.ir));
      chk("k16_out", 32'(k16_out), 32'(e.k16));
    end
  endtask

  task automatic take(input logic two);
    ir_take = 1'b1;
    ir_two  = two;
    tick();
    ir_take = 1'b0;
    ir_two  = 1'b0;
  endtask

  task automatic wait_grants(input int k);
    int base;
    int n;
    base = gcount;
    n    = 0;
    while (gcount < base + k && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("grant_wait", 32'(gcount - base), 32'(k));
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [15:0] tgt);
    pc_w   = 1'b1;
    pc_alu = tgt;
    tick();
    pc_w   = 1'b0;
    #1;
  endtask

  initial begin
    a_rst   = 1'b0;
    hold    = 1'b0;
    pc_w    = 1'b0;
    pc_alu  = '0;
    ir_take = 1'b0;
    ir_two  = 1'b0;
    mem_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_pc_out", 32'(pc_out), 32'h0000);
    chk("rst_ir_out", 32'(ir_out), 32'h0000);
    chk("rst_k16_out", 32'(k16_out), 32'h0000);

    // Reset release: words at 0x0000/0x0002 reach the head three cycles later.
    a_rst = 1'b1;
    #1;
    chk("c0_mem_req", 32'(mem_req), 32'd1);
    chk("c0_mem_addr", 32'(mem_addr), 32'h0000);
    @(posedge clk); #1;
    tick();
    chk("c2_ir_valid", 32'(ir_valid), 32'd0);
    tick();
    chk("c3_ir_valid", 32'(ir_valid), 32'd1);
    push_exp(16'h0000);
    check_head();

    // Sequential consumption with mixed instruction lengths.
    take(1'b1);
    push_exp(16'h0004);
    check_head();
    take(1'b0);
    push_exp(16'h0006);
    check_head();
    take(1'b1);
    push_exp(16'h000A);
    check_head();

    // Fill until requests stop, then hold with a take request that must be ignored.
    repeat (10) tick();
    chk("full_mem_req", 32'(mem_req), 32'd0);
    hold    = 1'b1;
    ir_take = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_mem_req", 32'(mem_req), 32'd0);
    end
    hold    = 1'b0;
    ir_take = 1'b0;
    push_exp(16'h000A);
    check_head();

    // Two-cycle memory: redirect with two requests in flight.
    lat = 2;
    take(1'b1);
    wait_grants(2);
    addr_q.push_back(16'h0040);
    addr_q.push_back(16'h0042);
    redirect(16'h0041);
    chk("redir_ir_valid", 32'(ir_valid), 32'd0);
    chk("redir_pc_out", 32'(pc_out), 32'h0040);
    push_exp(16'h0040);
    check_head();

    // Stalled grant: address must hold, then follow each redirect; last redirect wins.
    repeat (10) tick();
    mem_gnt = 1'b0;
    take(1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_mem_req", 32'(mem_req), 32'd1);
      chk("stall_mem_addr", 32'(mem_addr), 32'h0048);
      tick();
    end
    pc_w   = 1'b1;
    pc_alu = 16'h0101;
    #1;
    chk("redir_cycle_req", 32'(mem_req), 32'd0);
    tick();
    pc_w = 1'b0;
    #1;
    chk("stall_new_addr", 32'(mem_addr), 32'h0100);
    pc_w   = 1'b1;
    pc_alu = 16'h0200;
    tick();
    pc_alu = 16'h0300;
    tick();
    pc_w = 1'b0;
    #1;
    chk("b2b_mem_addr", 32'(mem_addr), 32'h0300);
    chk("b2b_pc_out", 32'(pc_out), 32'h0300);
    addr_q.push_back(16'h0300);
    addr_q.push_back(16'h0302);
    mem_gnt = 1'b1;
    push_exp(16'h0300);
    check_head();

    // Address wrap at the top of the space.
    addr_q.push_back(16'hFFFC);
    addr_q.push_back(16'hFFFE);
    addr_q.push_back(16'h0000);
    addr_q.push_back(16'h0002);
    redirect(16'hFFFC);
    push_exp(16'hFFFC);
    check_head();
    take(1'b0);
    push_exp(16'hFFFE);
    check_head();
    take(1'b1);
    push_exp(16'h0002);
    check_head();
    repeat (6) tick();
    chk("addr_q_drained", 32'(addr_q.size()), 32'd0);

    // Asynchronous reset in mid-cycle clears everything at once.
    #3;
    a_rst = 1'b0;
    #1;
    chk("arst_ir_valid", 32'(ir_valid), 32'd0);
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_pc_out", 32'(pc_out), 32'h0000);
    chk("arst_ir_out", 32'(ir_out), 32'h0000);
    chk("arst_mem_addr", 32'(mem_addr), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
